// File: rtl/md_arbiter_if.sv
// md_arbiter_if: two requester ports plus the shared single-port memory bus
interface md_arbiter_if;
  logic        req0, we0, ack0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, ack1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [1:0]  gnt;
  logic [31:0] AM, DM_, DM;
  logic        EW;
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, DM,
    output ack0, err0, rdata0, ack1, err1, rdata1, gnt, AM, DM_, EW
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, DM,
    input  ack0, err0, rdata0, ack1, err1, rdata1, gnt, AM, DM_, EW
  );
endinterface

// File: rtl/md_arbiter.sv
// md_arbiter: round-robin two-port arbiter sequencing single-word accesses to the data memory
module md_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         rst_n,
  md_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state_q;
  logic        win_q, we_q, last_q;
  logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q;
  logic        ack0_q, ack1_q, err0_q, err1_q;
  logic        win_d, acc, in_range;
  logic [31:0] rd_val;
  // tie goes to the port that was not served last
  assign win_d    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign acc      = state_q == ACCESS;
  assign in_range = addr_q[31:AW] == '0;
  assign rd_val   = in_range ? bus.DM : '0;
  assign bus.AM   = acc ? addr_q : '0;
  assign bus.DM_  = acc ? wdata_q : '0;
  assign bus.EW   = acc && we_q && in_range;
  assign bus.gnt  = acc ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.err0   = err0_q;
  assign bus.err1   = err1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  // IDLE latches the winner, ACCESS captures memory data, RESP pulses ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req0 || bus.req1) begin
          win_q   <= win_d;
          last_q  <= win_d;
          we_q    <= win_d ? bus.we1 : bus.we0;
          addr_q  <= win_d ? bus.addr1 : bus.addr0;
          wdata_q <= win_d ? bus.wdata1 : bus.wdata0;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (win_q) begin
            rdata1_q <= rd_val;
            ack1_q   <= 1'b1;
            err1_q   <= !in_range;
          end else begin
            rdata0_q <= rd_val;
            ack0_q   <= 1'b1;
            err0_q   <= !in_range;
          end
          state_q <= RESP;
        end
        default: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_md_arbiter.sv
// tb_md_arbiter: directed checks of arbitration, handshake, range rejection and reset
module tb_md_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [32];
  always #5 clk = ~clk;
  md_arbiter_if bus ();
  md_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.DM = mem[bus.AM[4:0]];
  // memory model: preset contents, write on falling edge
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
    forever begin
      @(negedge clk);
      if (bus.EW) mem[bus.AM[4:0]] = bus.DM_;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic p0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
  endtask
  task automatic p1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
  endtask
  initial begin
    p0(0, 0, 0, 0);
    p1(0, 0, 0, 0);
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ew", bus.EW, 0);
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    step;
    step;
    rst_n = 1'b1;
    p0(1, 1, 5, 32'h9);
    step;
    chk("wr_gnt", bus.gnt, 2'b01);
    chk("wr_ew", bus.EW, 1);
    chk("wr_am", bus.AM, 5);
    chk("wr_dm", bus.DM_, 9);
    chk("wr_ack_early", bus.ack0, 0);
    step;
    chk("wr_ack0", bus.ack0, 1);
    chk("wr_err0", bus.err0, 0);
    chk("wr_ew_resp", bus.EW, 0);
    chk("wr_gnt_resp", bus.gnt, 0);
    chk("wr_rdata0", bus.rdata0, 9);
    p0(0, 0, 0, 0);
    step;
    chk("wr_ack0_idle", bus.ack0, 0);
    chk("wr_mem5", mem[5], 9);
    p0(1, 0, 5, 0);
    step;
    chk("rd_ew", bus.EW, 0);
    step;
    chk("rd_ack0", bus.ack0, 1);
    chk("rd_rdata0", bus.rdata0, 9);
    p0(0, 0, 0, 0);
    step;
    rst_n = 1'b0;
    #1;
    chk("rst2_rdata0", bus.rdata0, 0);
    step;
    rst_n = 1'b1;
    p0(1, 0, 3, 0);
    p1(1, 0, 7, 0);
    step;
    chk("tie1_gnt0", bus.gnt, 2'b01);
    chk("tie1_am0", bus.AM, 3);
    step;
    chk("tie1_ack0", bus.ack0, 1);
    chk("tie1_ack1_no", bus.ack1, 0);
    chk("tie1_rdata0", bus.rdata0, 32'h103);
    p0(0, 0, 0, 0);
    step;
    chk("tie1_idle_ack1", bus.ack1, 0);
    step;
    chk("tie1_gnt1", bus.gnt, 2'b10);
    chk("tie1_am1", bus.AM, 7);
    step;
    chk("tie1_ack1", bus.ack1, 1);
    chk("tie1_ack0_no", bus.ack0, 0);
    chk("tie1_rdata1", bus.rdata1, 32'h107);
    p1(0, 0, 0, 0);
    step;
    p0(1, 0, 1, 0);
    p1(1, 0, 2, 0);
    for (int i = 0; i < 6; i++) begin
      step;
      chk($sformatf("cont%0d_gnt", i), bus.gnt, (i % 2) ? 2'b10 : 2'b01);
      step;
      chk($sformatf("cont%0d_ack0", i), bus.ack0, (i % 2) ? 0 : 1);
      chk($sformatf("cont%0d_ack1", i), bus.ack1, (i % 2) ? 1 : 0);
      step;
    end
    chk("cont_rdata0", bus.rdata0, 32'h101);
    chk("cont_rdata1", bus.rdata1, 32'h102);
    p0(0, 0, 0, 0);
    p1(1, 1, 32, 32'hDEAD_BEEF);
    step;
    chk("oor_ew", bus.EW, 0);
    chk("oor_gnt", bus.gnt, 2'b10);
    step;
    chk("oor_ack1", bus.ack1, 1);
    chk("oor_err1", bus.err1, 1);
    chk("oor_rdata1", bus.rdata1, 0);
    chk("oor_mem0", mem[0], 32'h100);
    p1(0, 0, 0, 0);
    step;
    chk("oor_err1_idle", bus.err1, 0);
    p0(1, 1, 10, 32'h1234);
    step;
    chk("mrst_ew_pre", bus.EW, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_ew", bus.EW, 0);
    chk("mrst_gnt", bus.gnt, 0);
    chk("mrst_am", bus.AM, 0);
    chk("mrst_ack0", bus.ack0, 0);
    chk("mrst_rdata1", bus.rdata1, 0);
    p0(0, 0, 0, 0);
    step;
    chk("mrst_mem10", mem[10], 32'h10A);
    rst_n = 1'b1;
    step;
    chk("mrst_ack0_after", bus.ack0, 0);
    chk("mrst_gnt_after", bus.gnt, 0);
    p0(1, 1, 4, 32'hA5A5);
    step;
    step;
    chk("b2b_ack0_a", bus.ack0, 1);
    chk("b2b_rdata0_a", bus.rdata0, 32'hA5A5);
    p0(0, 1, 6, 32'h5A5A);
    step;
    bus.req0 = 1'b1;
    chk("b2b_idle_ack0", bus.ack0, 0);
    chk("b2b_hold_idle", bus.rdata0, 32'hA5A5);
    step;
    chk("b2b_gnt", bus.gnt, 2'b01);
    chk("b2b_am", bus.AM, 6);
    chk("b2b_hold_acc", bus.rdata0, 32'hA5A5);
    step;
    chk("b2b_ack0_b", bus.ack0, 1);
    chk("b2b_rdata0_b", bus.rdata0, 32'h5A5A);
    p0(0, 0, 0, 0);
    step;
    p0(1, 0, 4, 0);
    p1(1, 0, 6, 0);
    step;
    chk("tie2_gnt1", bus.gnt, 2'b10);
    chk("tie2_am1", bus.AM, 6);
    step;
    chk("tie2_ack1", bus.ack1, 1);
    chk("tie2_ack0_no", bus.ack0, 0);
    chk("tie2_rdata1", bus.rdata1, 32'h5A5A);
    p1(0, 0, 0, 0);
    step;
    step;
    chk("tie2_gnt0", bus.gnt, 2'b01);
    step;
    chk("tie2_ack0", bus.ack0, 1);
    chk("tie2_rdata0", bus.rdata0, 32'hA5A5);
    p0(0, 0, 0, 0);
    step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/md_arbiter.md
# md_arbiter

Two-port arbiter and sequencer for the 32-word data memory. It lets two requesters share the memory's single address/data/write-enable port: port 0 is the CPU load/store stage and port 1 is the I/O/DMA side. Each request is a registered single-word read or write with a req/ack handshake. Ties are resolved round-robin, and accesses outside the memory's range are rejected.

## Interface
- DEPTH, 32, number of memory words (power of two)
- AW, 5, log2(DEPTH); address bits actually decoded
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; held high with operands stable until ack0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  32  port 0 word address
- wdata0  in  32  port 0 write data
- ack0  out  1  port 0 completion, one-cycle pulse
- err0  out  1  port 0 out-of-range flag, valid only with ack0
- rdata0  out  32  port 0 read data, valid with ack0, held until next ack0
- req1, we1, addr1, wdata1, ack1, err1, rdata1: same as port 0, for port 1
- gnt  out  2  one-hot owner of the memory during ACCESS; 00 otherwise
- AM  out  32  memory address
- DM_  out  32  memory write data
- EW  out  1  memory write enable; memory writes on falling clk
- DM  in  32  memory read data, combinational from AM

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not `last`. `last` resets to 1, so port 0 wins the first tie.
  - On a grant: latch winner id, we, addr and wdata into internal registers, set `last` to the winner, and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - AM = latched addr. DM_ = latched wdata. gnt = one-hot winner.
  - EW = latched we AND in_range, where in_range = (addr[31:AW] == 0).
  - At the end of the cycle: capture DM into the winner's rdata register (0 if out of range), then go to RESP.
  - A write also updates the winner's rdata, to the written value (DM after the falling-edge write).
- RESP (exactly 1 cycle):
  - Winner's ack = 1, and its err = !in_range.
  - EW = 0, gnt = 00, AM/DM_ = 0. Next state is IDLE unconditionally.
- Out-of-range access: no memory write, rdata = 0, err = 1. Otherwise a normal handshake.
- The non-winning port's rdata, ack and err are untouched.
- Requesters must drop req by the cycle after their ack. A req still high in IDLE is treated as a new request.
- Outputs in IDLE: AM = 0, DM_ = 0, EW = 0, gnt = 00, ack0/ack1/err0/err1 = 0.
- The memory-side outputs AM/DM_/EW/gnt are decoded combinationally from the state and latched registers. Only the memory sees them combinationally; all requester-side outputs are registered or state-decoded.

## Timing
- Latency: req sampled high at edge E0 → ACCESS in cycle E0..E1 → ack high in cycle E1..E2 → IDLE after E2.
- Earliest next grant is at edge E3, so throughput is 1 access per 3 cycles.
- The write occurs at the falling clk edge inside ACCESS. EW is stable for the whole ACCESS cycle and low in every other state.
- Simultaneous req0 and req1 in IDLE: one port is granted, and the other is served on the next IDLE sample if its req is still high. Two ports that continuously request alternate 0,1,0,1.
- Asynchronous reset at any point: immediately state = IDLE, EW = 0, gnt = 00, ack/err = 0, rdata0/rdata1 = 0, `last` = 1.
  - Reset during ACCESS before the falling edge means no memory write occurs.
  - A transaction in flight is dropped with no ack.
- Release of rst_n is sampled at the rising edge like any input. The first grant is possible at the first rising edge after release.

## Test plan
- Single write then read on port 0:
  - Write addr0 = 5, wdata0 = 0x0000_0009 → EW high only in ACCESS, ack0 at E1..E2, err0 = 0.
  - Then read addr0 = 5 → rdata0 = 0x9 with ack0.
- Tie with equal requests: req0 and req1 rise together as reads of addr 3 and 7 → port 0 acked first, port 1 acked 3 cycles later. Repeat the tie → port 1 now wins first.
- Continuous contention: both reqs held, re-asserted after each ack, for 6 transactions → grant order 0,1,0,1,0,1, with no ack on the idle port.
- Out of range: port 1 writes addr1 = 32, wdata1 = 0xDEAD_BEEF → EW stays 0, ack1 with err1 = 1, rdata1 = 0, memory word 0 unchanged.
- Reset mid-write: assert rst_n = 0 during ACCESS before the falling edge → EW drops immediately, no ack, target word unchanged, all outputs 0.
- Back-to-back on one port: req0 reasserted in the cycle after ack0 → next ACCESS starts exactly 3 cycles after the previous one, and rdata0 holds the old value until the new ack0.
